nibble_serial_adder: RTL and testbench

- Multi-cycle wide adder built from one 4-bit carry-lookahead slice.
- Adds two WIDTH-bit operands one nibble per cycle, least-significant nibble first, with the carry held in a register between nibbles.
- Uses a valid/ready handshake on both input and output, so it can sit between an operand source and a result consumer.

---
 rtl/nsa_pkg.sv | 12 +
 rtl/cla4_slice.sv | 29 ++
 rtl/nibble_serial_adder.sv | 128 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM states.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  // All carries expanded from generate/propagate so none ripples through another.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single CLA slice,
// LSB nibble first, with valid/ready handshakes on operands and result.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  cla4_slice u_slice (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Next-state and datapath; handshake flags are decoded from the next state
  // so they leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        sum_d   = (sum_q >> NIBBLE_W) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIB - 1)) begin
          cout_d  = slice_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH = 4, 16 and 32.
module tb_nibble_serial_adder;

  logic clk;
  logic rst_n;

  // Index 0: WIDTH=4, index 1: WIDTH=16, index 2: WIDTH=32
  logic [2:0]        in_valid_v;
  logic [2:0]        cin_v;
  logic [2:0]        out_ready_v;
  logic [2:0][31:0]  a_v;
  logic [2:0][31:0]  b_v;
  logic [2:0]        in_ready_w;
  logic [2:0]        out_valid_w;
  logic [2:0]        cout_w;
  logic [2:0]        busy_w;
  logic [3:0]        sum4;
  logic [15:0]       sum16;
  logic [31:0]       sum32;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .cin(cin_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
    .sum(sum4), .cout(cout_w[0]), .busy(busy_w[0])
  );

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
    .sum(sum16), .cout(cout_w[1]), .busy(busy_w[1])
  );

  nibble_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]),
    .sum(sum32), .cout(cout_w[2]), .busy(busy_w[2])
  );

  function automatic int wid(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 16 : 32);
  endfunction

  function automatic logic [32:0] obs(input int idx);
    logic [31:0] s;
    s = (idx == 0) ? 32'(sum4) : ((idx == 1) ? 32'(sum16) : sum32);
    return {cout_w[idx], s};
  endfunction

  // Reference: plain (WIDTH+1)-bit addition of the masked operands.
  function automatic logic [32:0] model(input int idx, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    logic [32:0] m;
    logic [32:0] f;
    m = (33'd1 << wid(idx)) - 33'd1;
    f = ({1'b0, a} & m) + ({1'b0, b} & m) + 33'(c);
    return {f[wid(idx)], 32'(f & m)};
  endfunction

  task automatic check(input string tag, input logic [32:0] o, input logic [32:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on DUT idx with gap_in idle cycles before and
  // gap_out cycles of backpressure once the result is presented.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input int gap_in, input int gap_out);
    int          lat;
    int          wait_n;
    logic [32:0] held;
    for (int i = 0; i < gap_in; i++) step();
    wait_n = 0;
    while (!in_ready_w[idx] && wait_n < 50) begin
      step();
      wait_n++;
    end
    check("in_ready_idle", 33'(in_ready_w[idx]), 33'd1);
    in_valid_v[idx] = 1'b1;
    a_v[idx]        = a;
    b_v[idx]        = b;
    cin_v[idx]      = c;
    exp_q.push_back(model(idx, a, b, c));
    step();
    // Operand changes after accept must not affect the result.
    in_valid_v[idx] = 1'b1;
    a_v[idx]        = $urandom;
    b_v[idx]        = $urandom;
    cin_v[idx]      = 1'($urandom_range(0, 1));
    check("busy_after_accept", 33'({busy_w[idx], in_ready_w[idx], out_valid_w[idx]}), 33'(3'b100));
    lat = 0;
    while (!out_valid_w[idx] && lat < 64) begin
      step();
      lat++;
    end
    check("latency", 33'(lat), 33'(wid(idx) / 4));
    held = obs(idx);
    for (int i = 0; i < gap_out; i++) begin
      out_ready_v[idx] = 1'b0;
      a_v[idx]         = $urandom;
      step();
      check("stall_hold", obs(idx), held);
      check("stall_flags", 33'({out_valid_w[idx], in_ready_w[idx], busy_w[idx]}), 33'(3'b101));
    end
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b1;
    check("queue_nonempty", 33'(exp_q.size()), 33'd1);
    if (exp_q.size() > 0) check("result", obs(idx), exp_q.pop_front());
    step();
    out_ready_v[idx] = 1'b0;
    check("after_handshake", 33'({out_valid_w[idx], in_ready_w[idx], busy_w[idx]}), 33'(3'b010));
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_v  = '0;
    cin_v       = '0;
    out_ready_v = '0;
    a_v         = '0;
    b_v         = '0;
    step();
    step();
    check("reset_out16", obs(1), 33'd0);
    check("reset_flags16", 33'({out_valid_w[1], in_ready_w[1], busy_w[1]}), 33'(3'b010));
    check("reset_flags4", 33'({out_valid_w[0], in_ready_w[0], busy_w[0]}), 33'(3'b010));
    rst_n = 1'b1;
    step();

    // Full carry ripple across every nibble.
    run_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 0);
    check("ffff_plus_1", obs(1), {1'b1, 32'h0});
    run_op(1, 32'h0000_1234, 32'h0000_4321, 1'b1, 1, 0);
    check("1234_4321_1", obs(1), {1'b0, 32'h5556});
    // Backpressure with in_valid toggled during DONE.
    run_op(1, 32'h0000_8000, 32'h0000_8000, 1'b0, 0, 5);
    check("8000_8000", obs(1), {1'b1, 32'h0});

    // Reset on the second RUN edge aborts the operation.
    in_valid_v[1] = 1'b1;
    a_v[1]        = 32'h0000_00FF;
    b_v[1]        = 32'h0000_0001;
    cin_v[1]      = 1'b0;
    step();
    in_valid_v[1] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_out", obs(1), 33'd0);
    check("abort_flags", 33'({out_valid_w[1], in_ready_w[1], busy_w[1]}), 33'(3'b010));
    run_op(1, 32'h0000_0002, 32'h0000_0003, 1'b0, 0, 0);
    check("after_abort", obs(1), 33'h5);

    // Single-nibble configuration.
    run_op(0, 32'h9, 32'h8, 1'b1, 0, 0);
    check("w4_9_8_1", obs(0), {1'b1, 32'h2});

    for (int k = 0; k < 500; k++)
      run_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3));
    for (int k = 0; k < 500; k++)
      run_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3));

    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
